// File: rtl/instruction_encoder_pkg.sv
// Shared constants for the instruction encoder.
// Holds the instruction formats, their opcodes, the substitute NOP word,
// the legal immediate ranges, the output-buffer states and a range helper.
package instruction_encoder_pkg;

  // Request format selector carried on in_fmt.
  typedef enum logic [1:0] {
    FMT_R   = 2'b00,
    FMT_LD  = 2'b01,
    FMT_SD  = 2'b10,
    FMT_BEQ = 2'b11
  } fmt_e;

  // Occupancy of the 2-entry output buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } fifo_state_e;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_SD  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;

  // addi x0,x0,0 -- emitted in place of a word whose immediate cannot be encoded.
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Load/store offsets are 12-bit signed.
  localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
  // Branch offsets are 13-bit signed with an implied zero LSB.
  localparam logic signed [31:0] IMMB_MIN  = -32'sd4096;
  localparam logic signed [31:0] IMMB_MAX  = 32'sd4094;

  // Inclusive signed range test.
  function automatic logic imm_in_range(input logic signed [31:0] v,
                                        input logic signed [31:0] lo,
                                        input logic signed [31:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/instruction_encoder_instr_pack.sv
// instr_pack: combinational field packing and immediate legality check.
// Ports:
//   fmt    - request format (R / LD / SD / BEQ)
//   rd, rs1, rs2, funct3, funct7 - instruction fields (funct7 used by R only)
//   imm    - two's-complement immediate (ignored for R)
//   instr  - packed 32-bit word, or NOP when the immediate is illegal
//   err    - high when the NOP was substituted
module instr_pack
  import instruction_encoder_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  logic signed [31:0] imm_s;
  logic               legal_s;
  logic [31:0]        word_s;

  assign imm_s = $signed(imm);

  // Select the format layout and decide whether the immediate fits it.
  always_comb begin
    word_s  = 32'h00000000;
    legal_s = 1'b1;
    case (fmt)
      FMT_R: begin
        word_s  = {funct7, rs2, rs1, funct3, rd, OPC_R};
        legal_s = 1'b1;
      end
      FMT_LD: begin
        word_s  = {imm[11:0], rs1, funct3, rd, OPC_LD};
        legal_s = imm_in_range(imm_s, IMM12_MIN, IMM12_MAX);
      end
      FMT_SD: begin
        word_s  = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_SD};
        legal_s = imm_in_range(imm_s, IMM12_MIN, IMM12_MAX);
      end
      FMT_BEQ: begin
        word_s  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BEQ};
        // Branch targets must be halfword aligned.
        legal_s = imm_in_range(imm_s, IMMB_MIN, IMMB_MAX) && (imm[0] == 1'b0);
      end
      default: begin
        word_s  = NOP_INSTR;
        legal_s = 1'b0;
      end
    endcase
  end

  // Substitute the NOP when the immediate could not be encoded.
  always_comb begin
    if (legal_s) begin
      instr = word_s;
      err   = 1'b0;
    end else begin
      instr = NOP_INSTR;
      err   = 1'b1;
    end
  end

endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: encodes RV-style R/LD/SD/BEQ requests into 32-bit words
// behind a 2-entry output buffer, tagging each popped word with a byte address.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid / in_ready - request handshake (in_ready is registered)
//   in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm - request fields
//   addr_clr            - synchronous clear of the address counter
//   out_valid/out_ready - output handshake
//   out_instr, out_err  - head word and its illegal-immediate flag
//   out_addr            - byte address of the head word
//   err_count           - saturating count of popped error words
module instruction_encoder
  import instruction_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_fmt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  input  logic        addr_clr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [7:0]  err_count
);

  fifo_state_e state_r;
  logic        in_ready_r;
  logic        out_valid_r;
  logic [31:0] head_instr_r;
  logic        head_err_r;
  logic [31:0] tail_instr_r;
  logic        tail_err_r;
  logic [31:0] addr_r;
  logic [7:0]  err_cnt_r;

  logic [31:0] pack_instr_s;
  logic        pack_err_s;
  logic        push_s;
  logic        pop_s;

  instr_pack u_pack (
    .fmt    (in_fmt),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .instr  (pack_instr_s),
    .err    (pack_err_s)
  );

  // in_ready is low in TWO, yet a request held there is still taken when the
  // consumer pops in the same cycle; this keeps out_ready off the in_ready path.
  assign push_s = in_valid && (in_ready_r || ((state_r == ST_TWO) && out_ready));
  assign pop_s  = out_valid_r && out_ready;

  // Buffer FSM: head register feeds the outputs, tail holds the second word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_EMPTY;
      in_ready_r   <= 1'b0;
      out_valid_r  <= 1'b0;
      head_instr_r <= 32'h00000000;
      head_err_r   <= 1'b0;
      tail_instr_r <= 32'h00000000;
      tail_err_r   <= 1'b0;
    end else begin
      in_ready_r <= 1'b1;
      case (state_r)
        ST_EMPTY: begin
          if (push_s) begin
            head_instr_r <= pack_instr_s;
            head_err_r   <= pack_err_s;
            state_r      <= ST_ONE;
            out_valid_r  <= 1'b1;
          end else begin
            out_valid_r  <= 1'b0;
          end
        end
        ST_ONE: begin
          if (push_s && pop_s) begin
            head_instr_r <= pack_instr_s;
            head_err_r   <= pack_err_s;
          end else if (push_s) begin
            tail_instr_r <= pack_instr_s;
            tail_err_r   <= pack_err_s;
            state_r      <= ST_TWO;
            in_ready_r   <= 1'b0;
          end else if (pop_s) begin
            state_r      <= ST_EMPTY;
            out_valid_r  <= 1'b0;
          end else begin
            state_r      <= ST_ONE;
          end
        end
        ST_TWO: begin
          if (push_s && pop_s) begin
            head_instr_r <= tail_instr_r;
            head_err_r   <= tail_err_r;
            tail_instr_r <= pack_instr_s;
            tail_err_r   <= pack_err_s;
            in_ready_r   <= 1'b0;
          end else if (pop_s) begin
            head_instr_r <= tail_instr_r;
            head_err_r   <= tail_err_r;
            state_r      <= ST_ONE;
          end else begin
            in_ready_r   <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Address counter: clear wins over the post-pop increment; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= 32'h00000000;
    end else if (addr_clr) begin
      addr_r <= 32'h00000000;
    end else if (pop_s) begin
      addr_r <= addr_r + 32'd4;
    end else begin
      addr_r <= addr_r;
    end
  end

  // Saturating count of error words leaving the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= 8'h00;
    end else if (pop_s && head_err_r && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_instr = head_instr_r;
  assign out_err   = head_err_r;
  assign out_addr  = addr_r;
  assign err_count = err_cnt_r;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed self-checking bench for instruction_encoder.
module tb_instruction_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fmt;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        addr_clr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic [7:0]  err_count;

  int checks;
  int failures;

  instruction_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .addr_clr  (addr_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [1:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] imm);
    in_valid  = 1'b1;
    in_fmt    = f;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
  endtask

  // Push one request into an empty buffer, check the head word, then pop it.
  task automatic one(input string tag, input logic [1:0] f, input logic [31:0] imm,
                     input logic [31:0] exp_instr, input logic exp_err,
                     input logic [31:0] exp_addr);
    req(f, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, imm);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_instr"}, out_instr, exp_instr);
    chk({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
    chk({tag, "_addr"}, out_addr, exp_addr);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_fmt    = 2'b00;
    in_rd     = 5'd0;
    in_rs1    = 5'd0;
    in_rs2    = 5'd0;
    in_funct3 = 3'd0;
    in_funct7 = 7'd0;
    in_imm    = 32'd0;
    addr_clr  = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready_up", {31'd0, in_ready}, 32'd1);

    // LD x5, 8(x2), funct3=011: one-cycle latency
    req(2'b01, 5'd5, 5'd2, 5'd0, 3'b011, 7'd0, 32'd8);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ld_valid", {31'd0, out_valid}, 32'd1);
    chk("ld_instr", out_instr, 32'h00813283);
    chk("ld_err", {31'd0, out_err}, 32'd0);
    chk("ld_addr", out_addr, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("ld_popped", {31'd0, out_valid}, 32'd0);
    chk("ld_addr_inc", out_addr, 32'd4);

    // Clear address, then SD followed by BEQ -8
    addr_clr = 1'b1;
    @(negedge clk);
    addr_clr = 1'b0;
    chk("clr_addr", out_addr, 32'd0);
    req(2'b10, 5'd0, 5'd2, 5'd5, 3'b011, 7'd0, 32'd16);
    @(negedge clk);
    req(2'b11, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'hFFFFFFF8);
    @(negedge clk);
    in_valid = 1'b0;
    chk("sd_two_in_ready", {31'd0, in_ready}, 32'd0);
    chk("sd_instr", out_instr, 32'h00513823);
    chk("sd_addr", out_addr, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("beq_instr", out_instr, 32'hFE208CE3);
    chk("beq_addr", out_addr, 32'd4);
    chk("beq_err", {31'd0, out_err}, 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    chk("beq_popped", {31'd0, out_valid}, 32'd0);
    chk("beq_addr_after", out_addr, 32'd8);

    // Illegal immediates: BEQ odd, LD 2048
    req(2'b11, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3);
    @(negedge clk);
    req(2'b01, 5'd5, 5'd2, 5'd0, 3'b011, 7'd0, 32'd2048);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bad_beq_instr", out_instr, 32'h00000013);
    chk("bad_beq_err", {31'd0, out_err}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bad_ld_instr", out_instr, 32'h00000013);
    chk("bad_ld_err", {31'd0, out_err}, 32'd1);
    chk("err_count_1", {24'd0, err_count}, 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
    chk("err_count_2", {24'd0, err_count}, 32'd2);
    chk("bad_addr_after", out_addr, 32'd16);

    // Range boundaries
    one("ld_max", 2'b01, 32'd2047, 32'h7FF00083, 1'b0, 32'd16);
    one("ld_min", 2'b01, 32'hFFFFF800, 32'h80000083, 1'b0, 32'd20);
    one("beq_max", 2'b11, 32'd4094, 32'h7E000FE3, 1'b0, 32'd24);
    one("beq_min", 2'b11, 32'hFFFFF000, 32'h80000063, 1'b0, 32'd28);
    one("beq_over", 2'b11, 32'd4096, 32'h00000013, 1'b1, 32'd32);
    one("sd_under", 2'b10, 32'hFFFFF7FF, 32'h00000013, 1'b1, 32'd36);
    chk("err_count_4", {24'd0, err_count}, 32'd4);
    // R ignores the immediate entirely
    req(2'b00, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFF);
    @(negedge clk);
    in_valid = 1'b0;
    chk("r_imm_ignored", out_instr, 32'h002081B3);
    chk("r_imm_err", {31'd0, out_err}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Back-pressure: fill to TWO, hold, then push and pop together
    req(2'b00, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    chk("bp_in_ready_0", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    req(2'b00, 5'd4, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    chk("bp_in_ready_1", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    req(2'b00, 5'd5, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
    chk("bp_head", out_instr, 32'h002081B3);
    @(negedge clk);
    chk("bp_hold_instr", out_instr, 32'h002081B3);
    chk("bp_hold_addr", out_addr, 32'd44);
    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("bp_swap_instr", out_instr, 32'h00208233);
    chk("bp_swap_addr", out_addr, 32'd48);
    chk("bp_swap_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_third_instr", out_instr, 32'h002082B3);
    chk("bp_third_addr", out_addr, 32'd52);
    chk("bp_third_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Reset while holding two words
    req(2'b01, 5'd5, 5'd2, 5'd0, 3'b011, 7'd0, 32'd8);
    @(negedge clk);
    req(2'b10, 5'd0, 5'd2, 5'd5, 3'b011, 7'd0, 32'd16);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mr_full", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mr_out_instr", out_instr, 32'd0);
    chk("mr_addr", out_addr, 32'd0);
    chk("mr_err_count", {24'd0, err_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_in_ready_up", {31'd0, in_ready}, 32'd1);
    chk("mr_no_stale", {31'd0, out_valid}, 32'd0);

    // addr_clr wins over a simultaneous pop increment
    req(2'b01, 5'd5, 5'd2, 5'd0, 3'b011, 7'd0, 32'd8);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("ac_addr_4", out_addr, 32'd4);
    req(2'b10, 5'd0, 5'd2, 5'd5, 3'b011, 7'd0, 32'd16);
    @(negedge clk);
    req(2'b11, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'hFFFFFFF8);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ac_head", out_instr, 32'h00513823);
    chk("ac_head_addr", out_addr, 32'd4);
    addr_clr  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    addr_clr  = 1'b0;
    out_ready = 1'b0;
    chk("ac_next_instr", out_instr, 32'hFE208CE3);
    chk("ac_next_addr", out_addr, 32'd0);
    chk("ac_next_valid", {31'd0, out_valid}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
